// File: rtl/amo_ctrl.sv
// LR/SC/AMO sequencer: read, modify, write on the data port, driving the reservation table.
// Define AMO_MINMAX_EN to build MIN/MAX/MINU/MAXU; otherwise those codes are illegal.
module amo_ctrl #(
    parameter int XLEN = 32,
    parameter int N_IDS = 1,
    localparam int IDW = (N_IDS > 1) ? $clog2(N_IDS) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req,
    input  logic [IDW-1:0]  i_id,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_ack,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_tbl_wr_en,
    output logic            o_tbl_set_res,
    output logic            o_tbl_check_res,
    output logic [IDW-1:0]  o_tbl_id,
    output logic [XLEN-1:0] o_tbl_addr,
    input  logic            i_tbl_gnt
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
`ifdef AMO_MINMAX_EN
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;
`endif

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, RD, RES, CHK, WR, DONE} state_t;

    state_t          state;
    logic [IDW-1:0]  id_q;
    logic [4:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] result;

    function automatic logic legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SWAP, OP_LR, OP_SC,
            OP_XOR, OP_OR, OP_AND: legal = 1'b1;
`ifdef AMO_MINMAX_EN
            OP_MIN, OP_MAX,
            OP_MINU, OP_MAXU: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] modify(
        input logic [4:0]      op,
        input logic [XLEN-1:0] old,
        input logic [XLEN-1:0] rs2
    );
        case (op)
            OP_ADD:  modify = old + rs2;
            OP_XOR:  modify = old ^ rs2;
            OP_OR:   modify = old | rs2;
            OP_AND:  modify = old & rs2;
            OP_SWAP: modify = rs2;
`ifdef AMO_MINMAX_EN
            OP_MIN:  modify = ($signed(old) < $signed(rs2)) ? old : rs2;
            OP_MAX:  modify = ($signed(old) > $signed(rs2)) ? old : rs2;
            OP_MINU: modify = (old < rs2) ? old : rs2;
            OP_MAXU: modify = (old > rs2) ? old : rs2;
`endif
            default: modify = rs2;
        endcase
    endfunction

    assign o_mem_addr = addr_q;
    assign o_tbl_addr = addr_q;
    assign o_tbl_id   = id_q;
    // Any completed store kills reservations on this address, ours included.
    assign o_tbl_wr_en = (state == WR) && i_mem_ack;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state           <= IDLE;
            id_q            <= '0;
            op_q            <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            result          <= '0;
            o_ack           <= 1'b0;
            o_rdata         <= '0;
            o_err           <= 1'b0;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_wdata     <= '0;
            o_tbl_set_res   <= 1'b0;
            o_tbl_check_res <= 1'b0;
        end else begin
            o_ack           <= 1'b0;
            o_rdata         <= '0;
            o_err           <= 1'b0;
            o_tbl_set_res   <= 1'b0;
            o_tbl_check_res <= 1'b0;
            unique case (state)
                IDLE: if (i_req) begin
                    id_q    <= i_id;
                    op_q    <= i_op;
                    addr_q  <= i_addr;
                    wdata_q <= i_wdata;
                    if (!legal(i_op)) begin
                        state  <= DONE;
                        result <= '0;
                        o_ack  <= 1'b1;
                        o_err  <= 1'b1;
                    end else if (i_op == OP_SC) begin
                        state           <= CHK;
                        o_tbl_check_res <= 1'b1;
                    end else begin
                        state     <= RD;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                    end
                end
                RD: if (i_mem_ack) begin
                    result <= i_mem_rdata;
                    if (op_q == OP_LR) begin
                        state         <= RES;
                        o_mem_req     <= 1'b0;
                        o_tbl_set_res <= 1'b1;
                    end else begin
                        state       <= WR;
                        o_mem_we    <= 1'b1;
                        o_mem_wdata <= modify(op_q, i_mem_rdata, wdata_q);
                    end
                end
                RES: begin
                    state   <= DONE;
                    o_ack   <= 1'b1;
                    o_rdata <= result;
                end
                CHK: if (i_tbl_gnt) begin
                    state       <= WR;
                    result      <= '0;
                    o_mem_req   <= 1'b1;
                    o_mem_we    <= 1'b1;
                    o_mem_wdata <= wdata_q;
                end else begin
                    state   <= DONE;
                    result  <= ONE;
                    o_ack   <= 1'b1;
                    o_rdata <= ONE;
                end
                WR: if (i_mem_ack) begin
                    state     <= DONE;
                    o_mem_req <= 1'b0;
                    o_mem_we  <= 1'b0;
                    o_ack     <= 1'b1;
                    o_rdata   <= result;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_ctrl.sv
// Directed bench for amo_ctrl with memory, reservation table and result model.
`timescale 1ns/1ps
module tb_amo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [0:0]  id;
    logic [4:0]  op;
    logic [31:0] addr, wdata;
    logic        ack, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        tbl_wr_en, tbl_set, tbl_chk, gnt;
    logic [0:0]  tbl_id;
    logic [31:0] tbl_addr;

    always #5 clk = ~clk;

    amo_ctrl #(.XLEN(32), .N_IDS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_id(id), .i_op(op),
        .i_addr(addr), .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata),
        .o_err(err), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata), .o_tbl_wr_en(tbl_wr_en),
        .o_tbl_set_res(tbl_set), .o_tbl_check_res(tbl_chk),
        .o_tbl_id(tbl_id), .o_tbl_addr(tbl_addr), .i_tbl_gnt(gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // memory with programmable wait states
    logic [31:0] mem [logic [31:0]];
    int waits = 0, wcnt = 0;
    int n_reqcyc = 0, n_memw = 0;
    logic [31:0] last_w;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            n_reqcyc++;
            if (wcnt >= waits) begin
                mem_ack = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    n_memw++;
                    last_w = mem_wdata;
                end
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mem_rdata = '0;
            wcnt = 0;
        end
    end

    // reservation table (single hart)
    logic        res_v = 1'b0;
    logic [31:0] res_a = '0;
    assign gnt = tbl_chk && res_v && (res_a == tbl_addr);

    always @(posedge clk) begin
        if (tbl_set) begin
            res_v <= 1'b1;
            res_a <= tbl_addr;
        end
        if (tbl_chk) res_v <= 1'b0;
        if (tbl_wr_en && tbl_addr == res_a) res_v <= 1'b0;
    end

    // expectations published by the driver
    logic        exp_valid = 1'b0;
    int          exp_cycle, cnt;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] last_rdata;
    logic        last_err;
    int          n_set = 0, n_chk = 0, n_wren = 0;

    always @(negedge clk) begin
        if (tbl_set) n_set++;
        if (tbl_chk) n_chk++;
        if (tbl_wr_en) n_wren++;
        check("strobe_onehot", 32'(int'(tbl_set) + int'(tbl_chk) + int'(tbl_wr_en) > 1), 32'd0);
        check("strobe_in_done", 32'(ack && (tbl_set || tbl_chk || tbl_wr_en)), 32'd0);
        if (exp_valid) begin
            cnt++;
            if (ack || cnt >= exp_cycle) begin
                check("ack_cycle", 32'(cnt), 32'(exp_cycle));
                check("ack", 32'(ack), 32'd1);
                check("rdata", rdata, exp_rdata);
                check("err", 32'(err), 32'(exp_err));
                last_rdata = rdata;
                last_err = err;
                exp_valid = 1'b0;
            end
        end else begin
            check("spurious_ack", 32'(ack), 32'd0);
        end
    end

    // architectural model
    logic        m_res_v = 1'b0;
    logic [31:0] m_res_a = '0;

    function automatic logic supported(input logic [4:0] o);
`ifdef AMO_MINMAX_EN
        return o inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                         5'b01000, 5'b01100, 5'b10000, 5'b10100, 5'b11000,
                         5'b11100};
`else
        return o inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                         5'b01000, 5'b01100};
`endif
    endfunction

    function automatic logic [31:0] amo_new(input logic [4:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            5'b00000: return a + b;
            5'b00100: return a ^ b;
            5'b01000: return a | b;
            5'b01100: return a & b;
            5'b10000: return (sa <= sb) ? a : b;
            5'b10100: return (sa >= sb) ? a : b;
            5'b11000: return (a <= b) ? a : b;
            5'b11100: return (a >= b) ? a : b;
            default:  return b;
        endcase
    endfunction

    task automatic do_req(input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] d, input int w);
        logic [31:0] old, e_rd, e_new;
        logic        e_err, e_write, sc_ok;
        int          e_lat, e_req, e_set, e_chk;
        old = mem_rd(a);
        e_err = 1'b0; e_write = 1'b0; e_new = old;
        e_set = 0; e_chk = 0; e_req = 0;
        sc_ok = m_res_v && (m_res_a == a);
        if (!supported(o)) begin
            e_err = 1'b1; e_rd = 0; e_lat = 1;
        end else if (o == 5'b00010) begin
            e_rd = old; e_lat = 3 + w; e_req = 1 + w; e_set = 1;
            m_res_v = 1'b1; m_res_a = a;
        end else if (o == 5'b00011) begin
            e_chk = 1;
            if (sc_ok) begin
                e_rd = 0; e_lat = 3 + w; e_req = 1 + w;
                e_write = 1'b1; e_new = d;
            end else begin
                e_rd = 1; e_lat = 2;
            end
            m_res_v = 1'b0;
        end else begin
            e_rd = old; e_lat = 3 + 2 * w; e_req = 2 + 2 * w;
            e_write = 1'b1; e_new = amo_new(o, old, d);
        end
        if (e_write && m_res_a == a) m_res_v = 1'b0;

        @(negedge clk);
        waits = w;
        req = 1'b1; op = o; addr = a; wdata = d; id = 1'b0;
        @(posedge clk);
        n_set = 0; n_chk = 0; n_wren = 0; n_reqcyc = 0; n_memw = 0;
        exp_rdata = e_rd; exp_err = e_err; exp_cycle = e_lat;
        cnt = 0;
        exp_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (!exp_valid) break;
        end
        if (exp_valid) begin
            checks++; errors++;
            $display("FAIL ack_timeout actual=none required=cycle %0d", e_lat);
            exp_valid = 1'b0;
        end
        req = 1'b0;
        check("set_res_pulses", 32'(n_set), 32'(e_set));
        check("check_res_pulses", 32'(n_chk), 32'(e_chk));
        check("wr_en_pulses", 32'(n_wren), 32'(e_write ? 1 : 0));
        check("mem_writes", 32'(n_memw), 32'(e_write ? 1 : 0));
        check("mem_req_cycles", 32'(n_reqcyc), 32'(e_req));
        check("mem_value", mem_rd(a), e_new);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; id = '0; op = '0; addr = '0; wdata = '0;
        mem[32'h100] = 32'h55;        mem[32'h200] = 32'h77;
        mem[32'h40]  = 32'hFFFFFFFF;  mem[32'h60]  = 32'h80000000;
        mem[32'h64]  = 32'h80000000;  mem[32'h90]  = 32'h00FF00F0;
        mem[32'h300] = 32'h5;         mem[32'h80]  = 32'h1234;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_strobes", 32'({tbl_wr_en, tbl_set, tbl_chk}), 32'd0);
        check("rst_tbl_addr", tbl_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_req(5'b00010, 32'h100, 32'h0, 0);
        check("lr_literal", last_rdata, 32'h55);
        do_req(5'b00011, 32'h100, 32'hAA, 0);
        check("sc_ok_literal", last_rdata, 32'h0);
        check("sc_ok_mem", mem_rd(32'h100), 32'hAA);
        do_req(5'b00011, 32'h200, 32'h11, 0);
        check("sc_fail_literal", last_rdata, 32'h1);
        check("sc_fail_mem", mem_rd(32'h200), 32'h77);
        do_req(5'b00000, 32'h40, 32'h2, 0);
        check("add_wrap_mem", mem_rd(32'h40), 32'h1);
        check("add_wrap_old", last_rdata, 32'hFFFFFFFF);
        do_req(5'b10000, 32'h60, 32'h1, 0);
        do_req(5'b11000, 32'h64, 32'h1, 0);
`ifdef AMO_MINMAX_EN
        check("min_literal", mem_rd(32'h60), 32'h80000000);
        check("minu_literal", mem_rd(32'h64), 32'h1);
`else
        check("min_off_err", 32'(last_err), 32'd1);
        check("minu_off_mem", mem_rd(32'h64), 32'h80000000);
`endif
        do_req(5'b10100, 32'h60, 32'h1, 2);
        do_req(5'b11100, 32'h64, 32'h7, 1);
        do_req(5'b00100, 32'h90, 32'h0F0F0F0F, 1);
        do_req(5'b01000, 32'h90, 32'h30000003, 0);
        do_req(5'b01100, 32'h90, 32'hF0F0FFFF, 2);
        do_req(5'b00010, 32'h300, 32'h0, 1);
        do_req(5'b00000, 32'h300, 32'h3, 0);
        do_req(5'b00011, 32'h300, 32'h9, 0);
        check("sc_after_store", last_rdata, 32'h1);
        do_req(5'b00101, 32'h90, 32'h1, 0);
        check("illegal_err", 32'(last_err), 32'd1);

        // abandon a SWAP during its second read wait
        @(negedge clk);
        waits = 3;
        req = 1'b1; op = 5'b00001; addr = 32'h80; wdata = 32'hBEEF;
        @(posedge clk);
        n_set = 0; n_chk = 0; n_wren = 0; n_memw = 0;
        @(negedge clk);
        check("abort_req_on", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_strobes", 32'(n_set + n_chk + n_wren), 32'd0);
        check("abort_writes", 32'(n_memw), 32'd0);
        check("abort_mem", mem_rd(32'h80), 32'h1234);
        do_req(5'b00001, 32'h80, 32'hBEEF, 1);
        check("swap_old", last_rdata, 32'h1234);
        check("swap_mem", mem_rd(32'h80), 32'hBEEF);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amo_ctrl.md
# amo_ctrl

Atomic memory operation controller for the A extension: accepts one LR/SC/AMO request at a time from the core's memory stage and sequences the read, modify and write transactions on the data memory port. It drives the control inputs of the LR/SC reservation table (set, check, invalidate-on-write) and consumes its grant. It also returns the architectural result (loaded value, or SC status) to the core.

## Interface
- XLEN, 32: data and address width.
- N_IDS, 1: number of hart IDs; reservation table depth.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-low.
- i_req  in  1  request valid; level, sampled only in IDLE.
- i_id  in  $clog2(N_IDS)  requesting hart ID.
- i_op  in  5  funct5 of the AMO instruction.
- i_addr  in  XLEN  word address.
- i_wdata  in  XLEN  rs2 operand.
- o_ack  out  1  one-cycle completion pulse.
- o_rdata  out  XLEN  result, valid while o_ack=1.
- o_err  out  1  illegal op, valid while o_ack=1.
- o_mem_req  out  1  memory request, held until i_mem_ack.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_addr  out  XLEN  memory address.
- o_mem_wdata  out  XLEN  write data.
- i_mem_ack  in  1  memory completion; read data valid this cycle.
- i_mem_rdata  in  XLEN  read data.
- o_tbl_wr_en  out  1  invalidate matching reservations.
- o_tbl_set_res  out  1  set reservation for o_tbl_id.
- o_tbl_check_res  out  1  SC check strobe.
- o_tbl_id  out  $clog2(N_IDS)  latched i_id.
- o_tbl_addr  out  XLEN  latched i_addr.
- i_tbl_gnt  in  1  reservation valid; combinational response to check.

## Operation
- Supported ops (i_op): ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100. Any other code is illegal.
- IDLE: when i_req=1, latch id, op, addr and wdata. Then go to CHK for SC, DONE for an illegal op (err=1, result 0), and RD otherwise.
- RD: o_mem_req=1, we=0. On i_mem_ack, capture old=i_mem_rdata into result. LR then goes to RES. An AMO registers new=f(old,wdata) and goes to WR.
- RES: o_tbl_set_res=1 for exactly one cycle, then DONE.
- CHK: o_tbl_check_res=1 for exactly one cycle; i_tbl_gnt is sampled here.
  - gnt=1: result=0, write data=wdata, next state WR.
  - gnt=0: result=1, next state DONE. The table clears the entry itself; no memory access.
- WR: o_mem_req=1, we=1, wdata=new (AMO) or rs2 (SC). o_tbl_wr_en = i_mem_ack, so it pulses in the ack cycle and kills every reservation on o_tbl_addr, including the writer's own. Then DONE.
- DONE: o_ack=1, o_rdata=result, o_err as latched; then IDLE.
- Arithmetic:
  - ADD wraps modulo 2^XLEN.
  - MIN/MAX compare as two's complement; MINU/MAXU compare unsigned.
  - XOR/OR/AND/SWAP are bitwise or replace.
- o_mem_addr, o_mem_we, o_mem_wdata, o_tbl_id and o_tbl_addr are stable for the whole of each request.
- o_tbl_wr_en, o_tbl_set_res and o_tbl_check_res are mutually exclusive and never assert in IDLE or DONE.

## Timing
- Reset (i_rst=0 at a clock edge): state=IDLE and every output 0, including o_rdata.
- Reset mid-operation: the request is abandoned and o_mem_req drops the next cycle. The memory side must tolerate a dropped request. No table strobe is issued.
- Latency, counted from the IDLE capture edge with zero-wait memory (ack in the first request cycle):
  - LR: o_ack in cycle 3.
  - AMO: o_ack in cycle 3.
  - SC success: o_ack in cycle 3.
  - SC fail: o_ack in cycle 2.
  - Illegal op: o_ack in cycle 1.
- Each memory wait cycle adds one cycle of latency.
- The core deasserts i_req in the cycle it sees o_ack=1. The earliest next capture is the cycle after DONE.
- i_req asserted outside IDLE is ignored.
- i_mem_ack outside RD/WR is ignored.

## Configuration
- AMO_MINMAX_EN:
  - Defined: MIN/MAX/MINU/MAXU are executed as specified.
  - Undefined: those four codes are treated as illegal (o_err=1, no memory access, o_rdata=0) and no comparator logic is built.

## Test plan
- LR at 0x100 (mem holds 0x55), then SC at 0x100 with rs2=0xAA, same id -> LR o_rdata=0x55; set_res pulses once; check_res pulses; gnt=1; write 0xAA to 0x100; wr_en pulses with ack; SC o_rdata=0.
- SC at 0x200 with no prior LR -> check_res pulse, gnt=0, no o_mem_req, o_rdata=1, o_ack in cycle 2.
- AMOADD at 0x40, mem=0xFFFFFFFF, rs2=2 -> write 0x00000001, o_rdata=0xFFFFFFFF, wr_en pulses once.
- AMOMIN vs AMOMINU, old=0x80000000, rs2=1 (macro defined) -> writes 0x80000000 and 0x00000001 respectively. With macro undefined -> o_err=1, no memory traffic.
- AMOSWAP with 3 wait cycles, i_rst=0 during the second RD wait -> o_mem_req=0 the next cycle, no table strobes, no o_ack. A fresh request after reset completes normally.
- Illegal op 00101 -> o_ack cycle 1, o_err=1, o_rdata=0, no memory or table activity.
